// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared defaults, arbiter state encoding and writeback entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_arbiter_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [0:0] {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback request ports, register-file write port and status.
//               Forwarding signals exist only when RF_WB_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              hold;
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              reg_write_en;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              busy;
`ifdef RF_WB_FWD_EN
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rf_data1;
   logic [DATA_W-1:0] rf_data2;
   logic [DATA_W-1:0] fwd_data1;
   logic [DATA_W-1:0] fwd_data2;
`endif

   modport slave (
      input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
`ifdef RF_WB_FWD_EN
      input  rd_addr1, rd_addr2, rf_data1, rf_data2,
      output fwd_data1, fwd_data2,
`endif
      output a_ready, b_ready, reg_write_en, write_reg, write_data, busy
   );

   modport master (
      output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
`ifdef RF_WB_FWD_EN
      output rd_addr1, rd_addr2, rf_data1, rf_data2,
      input  fwd_data1, fwd_data2,
`endif
      input  a_ready, b_ready, reg_write_en, write_reg, write_data, busy
   );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Power-of-two depth queue with combinational head and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 2
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         push_data,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         head_data,
   output logic      [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin merge of ALU and load writebacks into one RF port.
//               Define RF_WB_FWD_EN to add write-to-read bypass outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic             clk,
   input  wire logic             reset,
   regfile_wb_arbiter_if.slave   bus
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = ADDR_W + DATA_W;

   logic [CNT_W-1:0]   count_a, count_b;
   logic [ENTRY_W-1:0] head_a, head_b;
   logic               a_ready, b_ready;
   logic               push_a, push_b;
   logic               pop_a, pop_b;
   logic               a_nonempty, b_nonempty;

   arb_state_e         state_q, state_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  write_reg_q, write_reg_d;
   logic [DATA_W-1:0]  write_data_q, write_data_d;

   // Ready looks only at the registered count; a pop this cycle gives no credit.
   assign a_ready    = (count_a < CNT_W'(FIFO_DEPTH));
   assign b_ready    = (count_b < CNT_W'(FIFO_DEPTH));
   assign push_a     = bus.a_valid & a_ready;
   assign push_b     = bus.b_valid & b_ready;
   assign a_nonempty = (count_a != '0);
   assign b_nonempty = (count_b != '0);

   wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk       (clk),
      .reset     (reset),
      .push      (push_a),
      .push_data ({bus.a_addr, bus.a_data}),
      .pop       (pop_a),
      .head_data (head_a),
      .count     (count_a)
   );

   wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk       (clk),
      .reset     (reset),
      .push      (push_b),
      .push_data ({bus.b_addr, bus.b_data}),
      .pop       (pop_b),
      .head_data (head_b),
      .count     (count_b)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LAST_B;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (pop_a) begin
         state_d = LAST_A;
      end else if (pop_b) begin
         state_d = LAST_B;
      end
   end

   // On a tie the requester not granted last wins.
   always_comb begin
      pop_a = 1'b0;
      pop_b = 1'b0;
      if (!bus.hold) begin
         if (a_nonempty && (!b_nonempty || state_q == LAST_B)) begin
            pop_a = 1'b1;
         end else if (b_nonempty) begin
            pop_b = 1'b1;
         end
      end
   end

   always_comb begin
      we_d         = pop_a | pop_b;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (pop_a) begin
         {write_reg_d, write_data_d} = head_a;
      end else if (pop_b) begin
         {write_reg_d, write_data_d} = head_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q         <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         we_q         <= we_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.a_ready      = a_ready;
   assign bus.b_ready      = b_ready;
   assign bus.reg_write_en = we_q;
   assign bus.write_reg    = write_reg_q;
   assign bus.write_data   = write_data_q;
   assign bus.busy         = a_nonempty | b_nonempty | we_q;

`ifdef RF_WB_FWD_EN
   assign bus.fwd_data1 = (we_q && bus.rd_addr1 == write_reg_q) ? write_data_q : bus.rf_data1;
   assign bus.fwd_data2 = (we_q && bus.rd_addr2 == write_reg_q) ? write_data_q : bus.rf_data2;
`endif

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_W, 10, register data width; ADDR_W, 3, register address width; FIFO_DEPTH, 2, entries per requester queue (power of 2, at least 2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- hold, in, 1, freezes issue to the register file.
- a_valid, in, 1, ALU writeback request.
- a_ready, out, 1, queue A can accept.
- a_addr, in, ADDR_W, ALU destination register.
- a_data, in, DATA_W, ALU result.
- b_valid, in, 1, load writeback request.
- b_ready, out, 1, queue B can accept.
- b_addr, in, ADDR_W, load destination register.
- b_data, in, DATA_W, load data.
- reg_write_en, out, 1, register file write enable.
- write_reg, out, ADDR_W, register file write address.
- write_data, out, DATA_W, register file write data.
- busy, out, 1, any queue non-empty or write issuing.

Function
REQ-003 A transfer on port X SHALL occur when x_valid and x_ready are both high at a rising edge; the {addr,data} pair is pushed into queue X.
REQ-004 x_ready SHALL be high exactly when queue X holds fewer than FIFO_DEPTH entries, evaluated from registered count only (no same-cycle pop credit).
REQ-005 Each cycle with hold low, the arbiter SHALL pop at most one head entry: only A non-empty pops A; only B non-empty pops B; both non-empty pops the requester not granted last.
REQ-006 The arbiter state SHALL be LAST_A or LAST_B; a pop from A moves it to LAST_A, a pop from B to LAST_B, and no pop holds it.
REQ-007 The popped entry SHALL appear registered on write_reg/write_data with reg_write_en high in the following cycle, giving minimum latency 1 cycle from acceptance to write strobe.
REQ-008 reg_write_en SHALL be low in any cycle following a cycle with no pop; write_reg/write_data SHALL hold their last values when idle.
REQ-009 With hold high, no pop SHALL occur and pushes SHALL continue until queues fill.
REQ-010 Order within one requester SHALL be FIFO order; order across requesters is arbitration order only.
REQ-011 A simultaneous push and pop on the same queue SHALL leave its count unchanged and preserve FIFO order.
REQ-012 Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 busy SHALL equal (countA != 0) | (countB != 0) | reg_write_en.

Reset
REQ-014 While reset is high at a rising edge, the block SHALL clear both queues to empty, set state LAST_B (A wins first tie), and drive reg_write_en, write_reg and write_data to 0; a_ready and b_ready are 1 after reset.
REQ-015 Reset asserted mid-operation SHALL discard all queued and in-flight writes with no write strobe in the cycle after reset.

Configuration
REQ-016 With macro RF_WB_FWD_EN defined, the block SHALL add inputs rd_addr1 and rd_addr2 (ADDR_W) and rf_data1 and rf_data2 (DATA_W), and outputs fwd_data1 and fwd_data2 (DATA_W). fwd_dataN SHALL be write_data when reg_write_en is high and rd_addrN equals write_reg; otherwise it SHALL be rf_dataN.
REQ-017 Without RF_WB_FWD_EN, those ports and that logic SHALL be absent.

Structure
REQ-018 A shared package SHALL hold DATA_W and ADDR_W defaults, the arbiter state enumeration (LAST_A, LAST_B) and a wb_entry_t {addr, data} typedef.
REQ-019 The queue SHALL be one sub-module, wb_fifo, instantiated twice.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then a_valid with addr 4, data 0x155 for one cycle -> next cycle reg_write_en=1, write_reg=4, write_data=0x155; next cycle reg_write_en=0.
- A (addr 1, data 0x011) and B (addr 2, data 0x022) in the same cycle after reset -> A written first, B the cycle after.
- hold high, push 3 entries on A -> a_ready low after 2 accepted; the third is held off; release hold -> writes occur in push order on consecutive cycles.
- Both queues full, continuous traffic for 8 cycles -> strict A/B alternation and 8 writes.
- reset asserted with 2 queued entries -> no strobe follows; busy=0.
- With RF_WB_FWD_EN: write to addr 5 with data 0x3FF issuing, rd_addr1=5 and rf_data1=0 -> fwd_data1=0x3FF; rd_addr2=6 -> fwd_data2=rf_data2.
